// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding and
// default timing parameters for the 50 MHz board clock.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int DEFAULT_TICK_DIV        = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_conditioner.sv
// Conditions one active-low push-button: 2-flop synchronizer, debounce filter
// and a one-cycle pulse on each accepted press (debounced 1->0).
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic [1:0]    valid_sr;
  logic          armed;

  // armed is set only once a genuinely released sample has passed the
  // synchronizer, so a button held through reset cannot produce a press.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      level    <= 1'b1;
      cnt      <= '0;
      valid_sr <= 2'b00;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      valid_sr <= {valid_sr[0], 1'b1};
      press    <= 1'b0;
      if (valid_sr[1] && sync2) armed <= 1'b1;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= armed && !sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, 1 Hz tick prescaler and the
// IDLE/RUN/PAUSE/LAP sequencer driving the BCD counter and display register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       start_n,
  input  logic       lap_n,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          start_press, lap_press;
  logic          start_ev, lap_ev;
  logic          counting, tick;
  logic          clr_d, latch_d;
  logic [PW-1:0] prescaler;
  sw_state_e     state_q, state_d;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
    .clock (clock),
    .reset (reset),
    .key_n (start_n),
    .press (start_press)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_key (
    .clock (clock),
    .reset (reset),
    .key_n (lap_n),
    .press (lap_press)
  );

  // Presses are dropped while disabled; start has priority over lap.
  assign start_ev = enable && start_press;
  assign lap_ev   = enable && lap_press && !start_ev;
  assign counting = enable && (state_q == RUN || state_q == LAP);
  assign tick     = counting && (prescaler == PRE_LAST);

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    latch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev)    state_d = RUN;
        else if (lap_ev) clr_d   = 1'b1;
      end
      RUN: begin
        if (start_ev) begin
          state_d = PAUSE;
        end else if (lap_ev) begin
          state_d = LAP;
          latch_d = 1'b1;
        end
      end
      LAP: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = RUN;
      end
      PAUSE: begin
        if (start_ev) begin
          state_d = RUN;
        end else if (lap_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prescaler <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      lap_latch <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_en  <= tick;
      count_clr <= clr_d;
      lap_latch <= latch_d;
      if (state_d == IDLE)  prescaler <= '0;
      else if (tick)        prescaler <= '0;
      else if (counting)    prescaler <= prescaler + 1'b1;
    end
  end

  assign state     = state_q;
  assign disp_hold = (state_q == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=5, DEBOUNCE_CYCLES=3):
// directed button stimulus, a cycle model built from pin history, literal spot checks.
module tb_stopwatch_ctrl;

  localparam int TD   = 5;
  localparam int DEB  = 3;
  localparam int MAXE = 4096;

  // Next state per current state (IDLE, RUN, PAUSE, LAP) for each event.
  localparam int NEXT_ON_START [4] = '{1, 2, 1, 2};
  localparam int NEXT_ON_LAP   [4] = '{0, 3, 0, 1};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       start_n = 1'b1;
  logic       lap_n = 1'b1;
  logic       count_en, count_clr, lap_latch, disp_hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int ce_seen = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start_n   (start_n),
    .lap_n     (lap_n),
    .count_en  (count_en),
    .count_clr (count_clr),
    .lap_latch (lap_latch),
    .disp_hold (disp_hold),
    .state     (state)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int   e;
    int   st;
    int   presc;
    int   last_s;
    int   last_l;
    logic cen, clr, lat, ps, pl;
    logic lvl_s, lvl_l, arm_s, arm_l;
  } model_t;

  typedef struct packed {
    int   last;
    logic lvl;
    logic armed;
    logic pr;
  } deb_t;

  localparam model_t MODEL_RESET = '{e: 0, st: 0, presc: 0, last_s: 0, last_l: 0,
                                     cen: 1'b0, clr: 1'b0, lat: 1'b0, ps: 1'b0, pl: 1'b0,
                                     lvl_s: 1'b1, lvl_l: 1'b1, arm_s: 1'b0, arm_l: 1'b0};

  logic   hist_s [MAXE];
  logic   hist_l [MAXE];
  model_t mdl = MODEL_RESET;

  // Level seen by the filter at edge k: the pin two edges earlier, or released
  // while the synchronizer still holds its reset value.
  function automatic logic sync_sample(input logic which, input int k);
    if (k < 3) return 1'b1;
    return which ? hist_l[k-2] : hist_s[k-2];
  endfunction

  function automatic deb_t deb_step(input logic which, input int k, input deb_t d);
    deb_t r;
    logic all_diff;
    r    = d;
    r.pr = 1'b0;
    if (k - d.last >= DEB) begin
      all_diff = 1'b1;
      for (int j = k - DEB + 1; j <= k; j++)
        if (sync_sample(which, j) == d.lvl) all_diff = 1'b0;
      if (all_diff) begin
        r.lvl  = ~d.lvl;
        r.last = k;
        r.pr   = d.armed && !r.lvl;
      end
    end
    if (k >= 3 && sync_sample(which, k)) r.armed = 1'b1;
    return r;
  endfunction

  function automatic model_t model_next(input model_t m, input logic en);
    model_t n;
    logic   run, sev, lev;
    int     nst;
    deb_t   ds, dl;
    n   = m;
    n.e = m.e + 1;
    run = en && (m.st == 1 || m.st == 3);
    sev = en && m.ps;
    lev = en && m.pl && !sev;
    nst = m.st;
    if (sev)      nst = NEXT_ON_START[m.st];
    else if (lev) nst = NEXT_ON_LAP[m.st];
    n.st  = nst;
    n.clr = lev && (nst == 0);
    n.lat = lev && (m.st == 1);
    n.cen = run && (m.presc == TD - 1);
    if (nst == 0) n.presc = 0;
    else if (run) n.presc = (m.presc + 1) % TD;
    ds = deb_step(1'b0, n.e, '{last: m.last_s, lvl: m.lvl_s, armed: m.arm_s, pr: 1'b0});
    dl = deb_step(1'b1, n.e, '{last: m.last_l, lvl: m.lvl_l, armed: m.arm_l, pr: 1'b0});
    n.lvl_s = ds.lvl; n.last_s = ds.last; n.arm_s = ds.armed; n.ps = ds.pr;
    n.lvl_l = dl.lvl; n.last_l = dl.last; n.arm_l = dl.armed; n.pl = dl.pr;
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mdl <= MODEL_RESET;
    end else begin
      if (mdl.e >= MAXE - 2) $fatal(1, "model history overflow");
      hist_s[mdl.e + 1] <= start_n;
      hist_l[mdl.e + 1] <= lap_n;
      mdl <= model_next(mdl, enable);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("state",     32'(state),     32'(mdl.st));
    check("count_en",  32'(count_en),  32'(mdl.cen));
    check("count_clr", 32'(count_clr), 32'(mdl.clr));
    check("lap_latch", 32'(lap_latch), 32'(mdl.lat));
    check("disp_hold", 32'(disp_hold), 32'(mdl.st == 3));
  end

  task automatic expect_state(input string name, input int v);
    check(name, 32'(state), 32'(v));
    check({name, "_model"}, 32'(mdl.st), 32'(v));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (count_en) ce_seen++;
    end
  endtask

  // Pins low, wait until the resulting transition is visible, then release.
  task automatic press(input logic s, input logic l);
    if (s) start_n = 1'b0;
    if (l) lap_n = 1'b0;
    step(6);
    start_n = 1'b1;
    lap_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    step(3);
    reset = 1'b1;

    // Idle after reset
    ce_seen = 0;
    step(20);
    expect_state("idle_after_reset", 0);
    check("no_count_en_idle", ce_seen, 0);

    // Start: transition 6 edges after the pin falls, then 4 ticks in 20 cycles
    start_n = 1'b0;
    step(5);
    expect_state("before_start_transition", 0);
    step(1);
    expect_state("start_to_run", 1);
    start_n = 1'b1;
    ce_seen = 0;
    step(20);
    check("run_ticks_in_20", ce_seen, 4);

    // Pause with prescaler at 2, then resume
    step(1);
    press(1'b1, 1'b0);
    expect_state("run_to_pause", 2);
    ce_seen = 0;
    step(10);
    check("no_ticks_in_pause", ce_seen, 0);
    press(1'b1, 1'b0);
    expect_state("pause_to_run", 1);
    ce_seen = 0;
    step(2);
    check("resume_no_tick_yet", ce_seen, 0);
    step(1);
    check("resume_first_tick", ce_seen, 1);

    // Lap and back
    press(1'b0, 1'b1);
    expect_state("run_to_lap", 3);
    check("lap_latch_pulse", 32'(lap_latch), 1);
    check("disp_hold_in_lap", 32'(disp_hold), 1);
    ce_seen = 0;
    step(10);
    check("ticks_during_lap", ce_seen, 2);
    press(1'b0, 1'b1);
    expect_state("lap_to_run", 1);
    check("disp_hold_released", 32'(disp_hold), 0);
    step(6);

    // Bounce: never DEB consecutive low samples
    for (int i = 0; i < 10; i++) begin
      start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    start_n = 1'b1;
    step(10);
    expect_state("bounce_ignored", 1);

    // PAUSE + lap clears and returns to IDLE
    press(1'b1, 1'b0);
    expect_state("run_to_pause_2", 2);
    step(6);
    press(1'b0, 1'b1);
    expect_state("pause_to_idle", 0);
    check("count_clr_pulse", 32'(count_clr), 1);
    check("no_count_en_with_clr", 32'(count_en), 0);
    step(1);
    check("count_clr_one_cycle", 32'(count_clr), 0);
    step(5);

    // Simultaneous start+lap in RUN: start wins
    press(1'b1, 1'b0);
    expect_state("idle_to_run", 1);
    step(6);
    press(1'b1, 1'b1);
    expect_state("simultaneous_start_wins", 2);
    check("simultaneous_no_latch", 32'(lap_latch), 0);
    step(6);

    // enable=0: presses discarded, timing frozen
    press(1'b1, 1'b0);
    expect_state("pause_to_run_2", 1);
    step(6);
    enable  = 1'b0;
    ce_seen = 0;
    press(1'b1, 1'b0);
    step(6);
    press(1'b0, 1'b1);
    step(6);
    expect_state("disabled_press_ignored", 1);
    check("disabled_no_ticks", ce_seen, 0);
    enable = 1'b1;
    step(12);

    // Reset in LAP aborts immediately
    press(1'b0, 1'b1);
    expect_state("run_to_lap_2", 3);
    step(6);
    reset = 1'b0;
    #1;
    check("reset_state_immediate", 32'(state), 0);
    check("reset_disp_hold_immediate", 32'(disp_hold), 0);
    step(2);
    reset = 1'b1;
    step(4);

    // Button held through reset must be released and pressed again
    start_n = 1'b0;
    reset   = 1'b0;
    step(2);
    reset = 1'b1;
    step(12);
    expect_state("held_through_reset_ignored", 0);
    start_n = 1'b1;
    step(6);
    press(1'b1, 1'b0);
    expect_state("repress_after_reset", 1);
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
